// File: rtl/key_onehot_debounce4.sv
// Four-key synchroniser + debouncer resolving to a one-hot drive for the 4-to-2 encoder.
// Build option: define KEY_SYNC_EN to insert the 2-flop synchroniser ahead of the debouncers.
module key_onehot_debounce4 #(
  parameter int unsigned DB_CNT = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_raw,
  output logic       d0,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       valid,
  output logic       press,
  output logic       multi_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    LOCKOUT
  } state_t;

  logic [3:0] samp;

`ifdef KEY_SYNC_EN
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = key_raw;
`endif

  logic [3:0]       stb_q, stb_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // A sample matching the stable level restarts the count, so any bounce restarts debounce.
  always_comb begin
    stb_d = stb_q;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (samp[i] == stb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DB_CNT - 1)) begin
        stb_d[i] = samp[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stb_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      stb_q <= stb_d;
      cnt_q <= cnt_d;
    end
  end

  state_t     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic       press_q, press_d;
  logic       err_q, err_d;
  logic       stb_any, stb_one;

  assign stb_any = (stb_q != '0);
  assign stb_one = stb_any && ((stb_q & (stb_q - 4'd1)) == '0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    press_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stb_one) begin
          state_d = ACTIVE;
          sel_d   = stb_q;
          press_d = 1'b1;
        end else if (stb_any) begin
          state_d = LOCKOUT;
          err_d   = 1'b1;
        end
      end
      ACTIVE: begin
        // Rollover onto a still-held key is refused rather than auto-selected.
        if ((stb_q & sel_q) == '0) begin
          if (stb_any) begin
            state_d = LOCKOUT;
            err_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LOCKOUT: begin
        if (!stb_any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      press_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      press_q <= press_d;
      err_q   <= err_d;
    end
  end

  assign {d3, d2, d1, d0} = (state_q == ACTIVE) ? sel_q : 4'b0000;
  assign valid            = (state_q == ACTIVE);
  assign press            = press_q;
  assign multi_err        = err_q;

endmodule

// File: tb/tb_key_onehot_debounce4.sv
// Directed self-checking bench for key_onehot_debounce4 at DB_CNT=4; latency adapts to KEY_SYNC_EN.
module tb_key_onehot_debounce4;

  localparam int unsigned DB = 4;
`ifdef KEY_SYNC_EN
  localparam int unsigned SYNC = 2;
`else
  localparam int unsigned SYNC = 0;
`endif
  // Edges after the first sampling edge before outputs can react.
  localparam int unsigned L = DB + SYNC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_raw;
  logic       d0, d1, d2, d3, valid, press, multi_err;

  int n_checks = 0;
  int n_fail   = 0;

  key_onehot_debounce4 #(.DB_CNT(DB), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key_raw),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .valid     (valid),
    .press     (press),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  // {d3,d2,d1,d0,valid,press,multi_err}
  function automatic logic [6:0] obs();
    return {d3, d2, d1, d0, valid, press, multi_err};
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    key_raw = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_checks++;
      if (obs() !== 7'b0000_000) begin
        n_fail++;
        $display("FAIL reset_hold: obs=%b exp=%b", obs(), 7'b0000_000);
      end
    end
    rst_n = 1'b1;
    tick(L);
    n_checks++;
    if (obs() !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL reset_debouncing: obs=%b exp=%b", obs(), 7'b0000_000);
    end
    tick(1);
    n_checks++;
    if (obs() !== 7'b0000_001) begin
      n_fail++;
      $display("FAIL reset_multi_err: obs=%b exp=%b", obs(), 7'b0000_001);
    end
    tick(1);
    n_checks++;
    if (obs() !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL reset_lockout: obs=%b exp=%b", obs(), 7'b0000_000);
    end
    key_raw = 4'b0000;
    tick(L + 2);
  endtask

  task automatic test_clean_press();
    key_raw = 4'b0100;
    tick(L);
    n_checks++;
    if (obs() !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL press_early: obs=%b exp=%b", obs(), 7'b0000_000);
    end
    tick(1);
    n_checks++;
    if (obs() !== 7'b0100_110) begin
      n_fail++;
      $display("FAIL press_assert: obs=%b exp=%b", obs(), 7'b0100_110);
    end
    tick(1);
    n_checks++;
    if (obs() !== 7'b0100_100) begin
      n_fail++;
      $display("FAIL press_strobe_end: obs=%b exp=%b", obs(), 7'b0100_100);
    end
    tick(2);
    key_raw = 4'b0000;
    tick(L);
    n_checks++;
    if (obs() !== 7'b0100_100) begin
      n_fail++;
      $display("FAIL release_early: obs=%b exp=%b", obs(), 7'b0100_100);
    end
    tick(1);
    n_checks++;
    if (obs() !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL release_drop: obs=%b exp=%b", obs(), 7'b0000_000);
    end
    tick(2);
  endtask

  task automatic test_bounce();
    logic [3:0] pat [4];
    pat = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      key_raw = pat[i];
      tick(1);
      n_checks++;
      if (obs() !== 7'b0000_000) begin
        n_fail++;
        $display("FAIL bounce_toggle: obs=%b exp=%b", obs(), 7'b0000_000);
      end
    end
    key_raw = 4'b0001;
    tick(L);
    n_checks++;
    if (obs() !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL bounce_early: obs=%b exp=%b", obs(), 7'b0000_000);
    end
    tick(1);
    n_checks++;
    if (obs() !== 7'b0001_110) begin
      n_fail++;
      $display("FAIL bounce_accept: obs=%b exp=%b", obs(), 7'b0001_110);
    end
    key_raw = 4'b0000;
    tick(L + 2);
    n_checks++;
    if (obs() !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL bounce_release: obs=%b exp=%b", obs(), 7'b0000_000);
    end
  endtask

  task automatic test_simultaneous();
    key_raw = 4'b1010;
    tick(L);
    n_checks++;
    if (obs() !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL simul_early: obs=%b exp=%b", obs(), 7'b0000_000);
    end
    tick(1);
    n_checks++;
    if (obs() !== 7'b0000_001) begin
      n_fail++;
      $display("FAIL simul_multi_err: obs=%b exp=%b", obs(), 7'b0000_001);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_checks++;
      if (obs() !== 7'b0000_000) begin
        n_fail++;
        $display("FAIL simul_lockout: obs=%b exp=%b", obs(), 7'b0000_000);
      end
    end
    key_raw = 4'b0000;
    tick(L + 2);
  endtask

  task automatic test_rollover();
    key_raw = 4'b0010;
    tick(L + 1);
    n_checks++;
    if (obs() !== 7'b0010_110) begin
      n_fail++;
      $display("FAIL roll_key1: obs=%b exp=%b", obs(), 7'b0010_110);
    end
    key_raw = 4'b1010;
    for (int i = 0; i < int'(L) + 2; i++) begin
      tick(1);
      n_checks++;
      if (obs() !== 7'b0010_100) begin
        n_fail++;
        $display("FAIL roll_add_key3: obs=%b exp=%b", obs(), 7'b0010_100);
      end
    end
    key_raw = 4'b1000;
    tick(L);
    n_checks++;
    if (obs() !== 7'b0010_100) begin
      n_fail++;
      $display("FAIL roll_release_early: obs=%b exp=%b", obs(), 7'b0010_100);
    end
    tick(1);
    n_checks++;
    if (obs() !== 7'b0000_001) begin
      n_fail++;
      $display("FAIL roll_multi_err: obs=%b exp=%b", obs(), 7'b0000_001);
    end
    for (int i = 0; i < int'(L) + 3; i++) begin
      tick(1);
      n_checks++;
      if (obs() !== 7'b0000_000) begin
        n_fail++;
        $display("FAIL roll_lockout: obs=%b exp=%b", obs(), 7'b0000_000);
      end
    end
    key_raw = 4'b0000;
    tick(L + 2);
    key_raw = 4'b1000;
    tick(L + 1);
    n_checks++;
    if (obs() !== 7'b1000_110) begin
      n_fail++;
      $display("FAIL roll_key3_again: obs=%b exp=%b", obs(), 7'b1000_110);
    end
    key_raw = 4'b0000;
    tick(L + 2);
  endtask

  task automatic test_reset_mid();
    key_raw = 4'b0001;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    n_checks++;
    if (obs() !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL midrst_hold: obs=%b exp=%b", obs(), 7'b0000_000);
    end
    rst_n = 1'b1;
    tick(L);
    n_checks++;
    if (obs() !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL midrst_early: obs=%b exp=%b", obs(), 7'b0000_000);
    end
    tick(1);
    n_checks++;
    if (obs() !== 7'b0001_110) begin
      n_fail++;
      $display("FAIL midrst_accept: obs=%b exp=%b", obs(), 7'b0001_110);
    end
    key_raw = 4'b0000;
    tick(L + 2);
  endtask

  initial begin
    rst_n   = 1'b0;
    key_raw = 4'b0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_rollover();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
